// File: rtl/tile_binner_if.sv
// Point stream in and binned stream out for tile_binner.
// The design sits on the slave modport; the producer/consumer side uses master.
interface tile_binner_if #(
    parameter int COORD_W = 32,
    parameter int TILE_W  = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*COORD_W-1:0]   in_point;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*COORD_W-1:0]   out_point;
    logic [TILE_W-1:0]      out_tile;
    logic                   out_first;

    modport master (
        output in_valid, in_point, in_last, out_ready,
        input  in_ready, out_valid, out_point, out_tile, out_first
    );

    modport slave (
        input  in_valid, in_point, in_last, out_ready,
        output in_ready, out_valid, out_point, out_tile, out_first
    );
endinterface

// File: rtl/tile_binner.sv
// Bins a frame of {intensity,z,y,x} points into a GRID_X x GRID_Y tile grid, then
// drains them tile by tile in ascending index order with per-frame drop counters.
module tile_binner #(
    parameter int COORD_W    = 32,
    parameter int GRID_X     = 16,
    parameter int GRID_Y     = 16,
    parameter int TILE_SHIFT = 4,
    parameter int MAX_PTS    = 8,
    parameter int X_MIN      = 0,
    parameter int Y_MIN      = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    tile_binner_if.slave   bus,
    output logic           frame_done_o,
    output logic [15:0]    drop_range_o,
    output logic [15:0]    drop_full_o
);
    localparam int N_TILES = GRID_X * GRID_Y;
    localparam int TILE_W  = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int SLOT_W  = (MAX_PTS > 1) ? $clog2(MAX_PTS) : 1;
    localparam int CNT_W   = $clog2(MAX_PTS + 1);
    localparam int PT_W    = 4 * COORD_W;

    localparam logic signed [COORD_W:0] X_MIN_E = (COORD_W+1)'(X_MIN);
    localparam logic signed [COORD_W:0] Y_MIN_E = (COORD_W+1)'(Y_MIN);
    localparam logic signed [COORD_W:0] GX_E    = (COORD_W+1)'(GRID_X);
    localparam logic signed [COORD_W:0] GY_E    = (COORD_W+1)'(GRID_Y);
    localparam logic signed [COORD_W:0] ZERO_E  = '0;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                out_first_q;
    logic [TILE_W-1:0]   out_tile_q;
    logic [PT_W-1:0]     out_point_q;
    logic                frame_done_q;
    logic [15:0]         drop_range_q;
    logic [15:0]         drop_full_q;
    logic [TILE_W-1:0]   t_q;
    logic [SLOT_W-1:0]   p_q;
    logic                scan_done_q;
    logic [CNT_W-1:0]    cnt_q [N_TILES];
    logic [PT_W-1:0]     mem_q [N_TILES][MAX_PTS];

    logic signed [COORD_W:0] x_ext, y_ext, dx, dy, tx, ty;
    logic                    in_range;
    logic [TILE_W-1:0]       in_tile;
    logic                    tile_full;
    logic [SLOT_W-1:0]       wr_slot;
    logic                    accept;
    logic                    wr_en;
    logic [CNT_W-1:0]        cur_cnt;
    logic                    last_slot;
    logic                    last_tile;
    logic                    take;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        x_ext     = {bus.in_point[COORD_W-1], bus.in_point[COORD_W-1:0]};
        y_ext     = {bus.in_point[2*COORD_W-1], bus.in_point[2*COORD_W-1:COORD_W]};
        dx        = x_ext - X_MIN_E;
        dy        = y_ext - Y_MIN_E;
        tx        = dx >>> TILE_SHIFT;
        ty        = dy >>> TILE_SHIFT;
        in_range  = (tx >= ZERO_E) && (tx < GX_E) && (ty >= ZERO_E) && (ty < GY_E);
        in_tile   = TILE_W'(ty * GX_E + tx);
        tile_full = (cnt_q[in_tile] == CNT_W'(MAX_PTS));
        wr_slot   = SLOT_W'(cnt_q[in_tile]);
        accept    = (state_q == FILL) && bus.in_valid && in_ready_q;
        wr_en     = accept && in_range && !tile_full;

        cur_cnt   = cnt_q[t_q];
        last_slot = ((CNT_W'(p_q) + CNT_W'(1)) == cur_cnt);
        last_tile = (t_q == TILE_W'(N_TILES - 1));
        // A new item may be loaded when the output register is empty or being consumed.
        take      = !out_valid_q || bus.out_ready;
    end

    // NOTE: the point memory is deliberately not reset; a slot is only read below its tile count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[in_tile][wr_slot] <= bus.in_point;
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_tile_q   <= '0;
            out_point_q  <= '0;
            frame_done_q <= 1'b0;
            drop_range_q <= '0;
            drop_full_q  <= '0;
            t_q          <= '0;
            p_q          <= '0;
            scan_done_q  <= 1'b0;
            for (int i = 0; i < N_TILES; i++) cnt_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q      <= FILL;
                        in_ready_q   <= 1'b1;
                        drop_range_q <= '0;
                        drop_full_q  <= '0;
                        for (int i = 0; i < N_TILES; i++) cnt_q[i] <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (!in_range)      drop_range_q <= sat_inc(drop_range_q);
                        else if (tile_full) drop_full_q  <= sat_inc(drop_full_q);
                        else                cnt_q[in_tile] <= cnt_q[in_tile] + 1'b1;
                        if (bus.in_last) begin
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            t_q         <= '0;
                            p_q         <= '0;
                            scan_done_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (take) begin
                        if (scan_done_q) begin
                            out_valid_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            if (cur_cnt == '0) begin
                                out_valid_q <= 1'b0;
                            end else begin
                                out_valid_q <= 1'b1;
                                out_point_q <= mem_q[t_q][p_q];
                                out_tile_q  <= t_q;
                                out_first_q <= (p_q == '0);
                            end
                            if (cur_cnt == '0 || last_slot) begin
                                p_q <= '0;
                                if (last_tile) scan_done_q <= 1'b1;
                                else           t_q <= t_q + 1'b1;
                            end else begin
                                p_q <= p_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_point = out_point_q;
    assign bus.out_tile  = out_tile_q;
    assign bus.out_first = out_first_q;
    assign frame_done_o  = frame_done_q;
    assign drop_range_o  = drop_range_q;
    assign drop_full_o   = drop_full_q;
endmodule
